// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access stage.
// Holds the funct3 width codes, op kinds, FSM states and legality check.
package mem_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    localparam int XLEN  = 32;
    localparam int LANES = 4;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } mem_state_e;

    // Unsigned widths exist only for loads; alignment is natural.
    function automatic logic is_legal(
        input logic       is_store,
        input logic [2:0] funct3,
        input logic [1:0] lo
    );
        logic ok;
        case (funct3)
            F3_BYTE:   ok = 1'b1;
            F3_HALF:   ok = ~lo[0];
            F3_WORD:   ok = (lo == 2'b00);
            F3_BYTE_U: ok = ~is_store;
            F3_HALF_U: ok = ~is_store & ~lo[0];
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of EX request, data-cache and write-back signals.
// The slave view belongs to the access unit, master to its environment.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready;

    logic [31:0] dcache_addr;
    logic [31:0] dcache_din;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic        dcache_stall;
    logic [31:0] dcache_dout;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    modport slave (
        input  req_valid, req_is_store, req_funct3,
        input  req_addr, req_wdata, req_rd,
        output req_ready,
        output dcache_addr, dcache_din, dcache_we, dcache_re,
        input  dcache_stall, dcache_dout,
        output wb_valid, wb_rd, wb_data, fault
    );

    modport master (
        output req_valid, req_is_store, req_funct3,
        output req_addr, req_wdata, req_rd,
        input  req_ready,
        input  dcache_addr, dcache_din, dcache_we, dcache_re,
        output dcache_stall, dcache_dout,
        input  wb_valid, wb_rd, wb_data, fault
    );

endinterface

// File: rtl/load_aligner.sv
// Picks the addressed byte/half of a cache word and extends it.
// Word accesses are always aligned, so the shift is zero for them.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = dout >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = shifted[15:0];
        case (funct3)
            F3_BYTE:   data = {{24{byte_v[7]}}, byte_v};
            F3_HALF:   data = {{16{half_v[15]}}, half_v};
            F3_WORD:   data = shifted;
            F3_BYTE_U: data = {24'h0, byte_v};
            F3_HALF_U: data = {16'h0, half_v};
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store per handshake from EX.
// Holds the cache request through stalls and registers load results.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  we_q, we_d;
    logic        re_q, re_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;

    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] load_val;
    logic        legal;

    load_aligner u_align (
        .dout   (bus.dcache_dout),
        .lane   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_val)
    );

    // Lane mask and replicated data for the incoming store.
    always_comb begin
        case (bus.req_funct3)
            F3_BYTE: begin
                st_mask = 4'b0001 << bus.req_addr[1:0];
                st_data = {4{bus.req_wdata[7:0]}};
            end
            F3_HALF: begin
                st_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = bus.req_wdata;
            end
        endcase
        legal = is_legal(bus.req_is_store, bus.req_funct3,
                         bus.req_addr[1:0]);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        re_d       = re_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (legal) begin
                        state_d = ISSUE;
                        addr_d  = bus.req_addr;
                        f3_d    = bus.req_funct3;
                        rd_d    = bus.req_rd;
                        if (bus.req_is_store == OP_STORE) begin
                            we_d  = st_mask;
                            din_d = st_data;
                            re_d  = 1'b0;
                        end else begin
                            we_d  = 4'b0000;
                            din_d = '0;
                            re_d  = 1'b1;
                        end
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!bus.dcache_stall) begin
                    we_d  = 4'b0000;
                    din_d = '0;
                    re_d  = 1'b0;
                    if (re_q) begin
                        state_d = RESP;
                    end else begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end
                end
            end
            RESP: begin
                if (!bus.dcache_stall) begin
                    state_d    = IDLE;
                    addr_d     = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_val;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                din_d   = '0;
                we_d    = 4'b0000;
                re_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= '0;
            re_q       <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            re_q       <= re_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.dcache_addr = addr_q;
    assign bus.dcache_din  = din_q;
    assign bus.dcache_we   = we_q;
    assign bus.dcache_re   = re_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Directed cases plus random ops against a byte-level reference model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes, 0 when the encoding is not supported.
    function automatic int ref_size(input bit st, input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return st ? 0 : 1;
            3'd5: return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit st, input logic [2:0] f3,
                                     input logic [31:0] a);
        int sz;
        sz = ref_size(st, f3);
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    function automatic logic [3:0] ref_mask(input int sz,
                                            input logic [31:0] a);
        logic [3:0] m;
        int off;
        m = '0;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_din(input int sz,
                                            input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = w[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] dout);
        int sz;
        logic [31:0] v;
        logic [31:0] keep;
        sz = ref_size(1'b0, f3);
        v = dout >> (8 * (a % 4));
        if (sz < 4) begin
            keep = (32'd1 << (8 * sz)) - 32'd1;
            v = v & keep;
            if (!f3[2] && v[8*sz-1]) v = v | ~keep;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_rd       = '0;
        bus.dcache_stall = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " ready"}, bus.req_ready, 1'b1);
        chk({tag, " re"}, bus.dcache_re, 1'b0);
        chk({tag, " we"}, bus.dcache_we, 4'b0);
        chk({tag, " addr"}, bus.dcache_addr, 32'h0);
        chk({tag, " din"}, bus.dcache_din, 32'h0);
        chk({tag, " wb_valid"}, bus.wb_valid, 1'b0);
        chk({tag, " wb_rd"}, bus.wb_rd, 5'd0);
        chk({tag, " wb_data"}, bus.wb_data, 32'h0);
        chk({tag, " fault"}, bus.fault, 1'b0);
    endtask

    // Drives one op from a negedge with the ready check, then follows it
    // cycle by cycle until the unit is back in IDLE.
    task automatic do_op(input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] rd, input logic [31:0] dout,
                         input int is_st, input int rs_st);
        int sz;
        sz = ref_size(st, f3);
        chk("pre ready", bus.req_ready, 1'b1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = w;
        bus.req_rd       = rd;
        bus.dcache_stall = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        if (!ref_legal(st, f3, a)) begin
            chk("flt fault", bus.fault, 1'b1);
            chk("flt we", bus.dcache_we, 4'b0);
            chk("flt re", bus.dcache_re, 1'b0);
            chk("flt wb_valid", bus.wb_valid, 1'b0);
            chk("flt ready", bus.req_ready, 1'b1);
            @(negedge clk);
            chk("flt pulse", bus.fault, 1'b0);
            return;
        end
        for (int i = 0; i <= is_st; i++) begin
            chk("iss addr", bus.dcache_addr, a);
            chk("iss we", bus.dcache_we, st ? ref_mask(sz, a) : 4'b0);
            chk("iss re", bus.dcache_re, !st);
            if (st) chk("iss din", bus.dcache_din, ref_din(sz, w));
            chk("iss ready", bus.req_ready, 1'b0);
            chk("iss fault", bus.fault, 1'b0);
            bus.dcache_stall = (i < is_st);
            @(negedge clk);
        end
        if (st) begin
            bus.dcache_stall = 1'b0;
            chk("st ready", bus.req_ready, 1'b1);
            chk("st we", bus.dcache_we, 4'b0);
            chk("st wb_valid", bus.wb_valid, 1'b0);
            return;
        end
        for (int i = 0; i <= rs_st; i++) begin
            chk("rsp re", bus.dcache_re, 1'b0);
            chk("rsp ready", bus.req_ready, 1'b0);
            chk("rsp wb_valid", bus.wb_valid, 1'b0);
            bus.dcache_stall = (i < rs_st);
            bus.dcache_dout  = (i < rs_st) ? $urandom : dout;
            @(negedge clk);
        end
        bus.dcache_stall = 1'b0;
        bus.dcache_dout  = $urandom;
        chk("ld wb_valid", bus.wb_valid, 1'b1);
        chk("ld wb_data", bus.wb_data, ref_load(f3, a, dout));
        chk("ld wb_rd", bus.wb_rd, rd);
        chk("ld ready", bus.req_ready, 1'b1);
        chk("ld fault", bus.fault, 1'b0);
        @(negedge clk);
        chk("ld pulse", bus.wb_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] dv;
        logic [31:0] ra;
        logic [2:0]  rf;
        bit          rst_st;
        idle_inputs();
        bus.dcache_dout = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0);
        do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 0, 0, 0);
        do_op(1'b1, 3'd1, 32'h102, 32'h00001234, 5'd0, 0, 0, 0);

        dv = 32'h80F17F02;
        do_op(1'b0, 3'd0, 32'h203, 0, 5'd3, dv, 0, 0);
        do_op(1'b0, 3'd4, 32'h203, 0, 5'd4, dv, 0, 0);
        do_op(1'b0, 3'd1, 32'h202, 0, 5'd5, dv, 0, 0);
        do_op(1'b0, 3'd5, 32'h200, 0, 5'd6, dv, 0, 0);
        do_op(1'b0, 3'd2, 32'h200, 0, 5'd0, dv, 0, 0);

        do_op(1'b0, 3'd2, 32'h102, 0, 5'd1, dv, 0, 0);
        do_op(1'b0, 3'd1, 32'h101, 0, 5'd1, dv, 0, 0);
        do_op(1'b0, 3'd3, 32'h100, 0, 5'd1, dv, 0, 0);
        do_op(1'b1, 3'd4, 32'h100, 0, 5'd1, dv, 0, 0);

        do_op(1'b0, 3'd2, 32'h300, 0, 5'd9, 32'hCAFEF00D, 3, 2);

        // Reset while the load waits in RESP.
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd2;
        bus.req_addr     = 32'h400;
        bus.req_rd       = 5'd7;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        @(negedge clk);
        chk("mid re", bus.dcache_re, 1'b0);
        chk("mid ready", bus.req_ready, 1'b0);
        reset = 1'b1;
        bus.dcache_dout = 32'h12345678;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midrst");
        @(negedge clk);
        chk("midrst wb_valid", bus.wb_valid, 1'b0);
        chk("midrst ready2", bus.req_ready, 1'b1);

        for (int n = 0; n < 300; n++) begin
            rst_st = $urandom_range(0, 1);
            rf     = 3'($urandom_range(0, 7));
            ra     = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ra[1:0] = 2'b00;
                if ($urandom_range(0, 1) == 1) ra[1:0] = 2'($urandom_range(0, 3));
            end
            do_op(rst_st, rf, ra, $urandom, 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
